// File: rtl/ex_alu_consumer_if.sv
// Control/operand bus between the ALU control queue and the execute-stage consumer.
// master = queue/upstream side, slave = ex_alu_consumer.
interface ex_alu_consumer_if #(
    parameter int WIDTH = 64
);
    logic             Stall;
    logic             InValid;
    logic [2:0]       ALUCntrl;
    logic             FlagE;
    logic             FwdALU;
    logic             ShiftDir;
    logic             ShiftToALUB;
    logic [5:0]       Shamt;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             ResultValid;
    logic [3:0]       Flags;
    logic [3:0]       CondFlags;

    modport master (
        output Stall, InValid, ALUCntrl, FlagE, FwdALU, ShiftDir, ShiftToALUB, Shamt, A, B,
        input  Result, ResultValid, Flags, CondFlags
    );

    modport slave (
        input  Stall, InValid, ALUCntrl, FlagE, FwdALU, ShiftDir, ShiftToALUB, Shamt, A, B,
        output Result, ResultValid, Flags, CondFlags
    );
endinterface

// File: rtl/ex_alu_consumer.sv
// LEGv8 execute stage: shifter + ALU, registered EX/MEM result, NZCV register, ALU forwarding.
// Optional macro EX_FLAG_BYPASS_EN: CondFlags shows this cycle's flags combinationally.
module ex_alu_consumer #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    ex_alu_consumer_if.slave  bus
);
    logic [WIDTH-1:0] result_q;
    logic             valid_q;
    logic [3:0]       flags_q;

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_b;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             flag_c;
    logic             flag_v;
    logic [3:0]       new_flags;

    assign accept = bus.InValid & ~bus.Stall;

    // Forwarding reads the result register even when it is not marked valid.
    always_comb begin
        op_a = bus.FwdALU ? result_q : bus.A;
        shifted = '0;
        if ({26'd0, bus.Shamt} < 32'(WIDTH)) begin
            shifted = bus.ShiftDir ? (op_a >> bus.Shamt) : (op_a << bus.Shamt);
        end
        op_b = bus.ShiftToALUB ? shifted : bus.B;
    end

    // Subtract is done as opA + ~opB + 1 so the carry-out directly means "no borrow".
    always_comb begin
        is_sub = (bus.ALUCntrl == 3'b011);
        add_b  = is_sub ? ~op_b : op_b;
        sum    = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
        alu_res = '0;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        case (bus.ALUCntrl)
            3'b000: alu_res = op_b;
            3'b010, 3'b011: begin
                alu_res = sum[WIDTH-1:0];
                flag_c  = sum[WIDTH];
                flag_v  = (op_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'b100: alu_res = op_a & op_b;
            3'b101: alu_res = op_a | op_b;
            3'b110: alu_res = op_a ^ op_b;
            default: alu_res = '0;
        endcase
        new_flags = {alu_res[WIDTH-1], (alu_res == '0), flag_c, flag_v};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            flags_q  <= 4'b0000;
        end else if (!bus.Stall) begin
            valid_q <= bus.InValid;
            if (bus.InValid) begin
                result_q <= alu_res;
                if (bus.FlagE) begin
                    flags_q <= new_flags;
                end
            end
        end
    end

    assign bus.Result      = result_q;
    assign bus.ResultValid = valid_q;
    assign bus.Flags       = flags_q;

`ifdef EX_FLAG_BYPASS_EN
    assign bus.CondFlags = (accept && bus.FlagE) ? new_flags : flags_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign bus.CondFlags = flags_q;
`endif
endmodule
